// File: rtl/frame_rx_pkg.sv
// Shared types and constants for the frame receive controller.
package frame_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    PAYLOAD,
    CSUM,
    DELIVER
  } state_t;

  localparam logic [1:0] ERR_LEN     = 2'd0;
  localparam logic [1:0] ERR_CSUM    = 2'd1;
  localparam logic [1:0] ERR_OVERRUN = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

  // Width of a counter that must hold values 0..max_len inclusive.
  function automatic int cnt_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/frame_rx_buffer.sv
// Payload buffer: one synchronous write port, one asynchronous read port.
// Contents are not reset; the controller only exposes them while delivering.
module frame_rx_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AW         = 4
) (
  input  logic                  clk_i,
  input  logic                  wr_en_i,
  input  logic [AW-1:0]         wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic [AW-1:0]         rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Store one payload byte per strobe.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/frame_rx_controller.sv
// Frame receive controller: parses SOF | LEN | PAYLOAD | CSUM from the byte
// receiver, buffers the payload and streams good frames out over valid/ready.
// Optional feature: define FRAME_RX_TIMEOUT_EN to abort a frame whose byte
// gap reaches TIMEOUT_CYCLES.
//
// state   | meaning
// IDLE    | hunting for SOF, other bytes dropped
// LEN     | next strobe is the payload length
// PAYLOAD | writing payload bytes into the buffer
// CSUM    | next strobe is compared against the running sum
// DELIVER | streaming the buffer to the consumer
module frame_rx_controller
  import frame_rx_pkg::*;
#(
  parameter int                    DATA_WIDTH     = 8,
  parameter int                    MAX_LEN        = 16,
  parameter logic [DATA_WIDTH-1:0] SOF_BYTE       = DATA_WIDTH'(SOF_DEFAULT),
  parameter int                    TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [DATA_WIDTH-1:0] byte_i,
  input  logic                  byte_stb_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  last_o,
  output logic                  frame_ok_o,
  output logic                  frame_err_o,
  output logic [1:0]            err_code_o,
  output logic                  busy_o
);

  localparam int CNT_W = cnt_width(MAX_LEN);
  localparam int AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      len_q, wr_ptr_q, rd_ptr_q;
  logic [DATA_WIDTH-1:0] sum_q, rd_data;
  logic                  ovr_pend_q;
  logic                  len_bad, csum_bad, wr_last, rd_last, xfer, last_xfer;
  logic                  timeout_hit, buf_we;

  assign len_bad   = (byte_i == '0) || (byte_i > DATA_WIDTH'(MAX_LEN));
  assign csum_bad  = (byte_i != sum_q);
  assign wr_last   = (wr_ptr_q == len_q - CNT_W'(1));
  assign rd_last   = (rd_ptr_q == len_q - CNT_W'(1));
  assign xfer      = (state_q == DELIVER) && ready_i;
  assign last_xfer = xfer && rd_last;
  assign buf_we    = (state_q == PAYLOAD) && byte_stb_i;

`ifdef FRAME_RX_TIMEOUT_EN
  localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [GAP_W-1:0] gap_q;
  logic             in_frame;

  assign in_frame = (state_q == LEN) || (state_q == PAYLOAD) || (state_q == CSUM);

  // Count idle cycles since the last strobe while a frame is being parsed.
  always_ff @(posedge clk_i) begin
    if (!reset_i || !in_frame || byte_stb_i) begin
      gap_q <= '0;
    end else begin
      gap_q <= gap_q + GAP_W'(1);
    end
  end

  assign timeout_hit = in_frame && !byte_stb_i && (gap_q == GAP_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  frame_rx_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (MAX_LEN),
    .AW         (AW)
  ) u_buffer (
    .clk_i     (clk_i),
    .wr_en_i   (buf_we),
    .wr_addr_i (wr_ptr_q[AW-1:0]),
    .wr_data_i (byte_i),
    .rd_addr_i (rd_ptr_q[AW-1:0]),
    .rd_data_o (rd_data)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: everything but DELIVER advances on a byte strobe.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (byte_stb_i && (byte_i == SOF_BYTE)) state_d = LEN;
      LEN:     if (byte_stb_i) state_d = len_bad ? IDLE : PAYLOAD;
      PAYLOAD: if (byte_stb_i && wr_last) state_d = CSUM;
      CSUM:    if (byte_stb_i) state_d = csum_bad ? IDLE : DELIVER;
      DELIVER: if (last_xfer) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (timeout_hit) state_d = IDLE;
  end

  // Length, pointers, running checksum and the deferred overrun flag.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      len_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      sum_q      <= '0;
      ovr_pend_q <= 1'b0;
    end else begin
      // An overrun strobe landing on the final transfer would collide with
      // frame_ok_o, so its error pulse is pushed into the following IDLE cycle.
      ovr_pend_q <= (state_q == DELIVER) && byte_stb_i && last_xfer;
      case (state_q)
        LEN: begin
          if (byte_stb_i && !len_bad) begin
            len_q    <= byte_i[CNT_W-1:0];
            sum_q    <= byte_i;
            wr_ptr_q <= '0;
          end
        end
        PAYLOAD: begin
          if (byte_stb_i) begin
            wr_ptr_q <= wr_ptr_q + CNT_W'(1);
            sum_q    <= sum_q + byte_i;
          end
        end
        CSUM: begin
          if (byte_stb_i) rd_ptr_q <= '0;
        end
        DELIVER: begin
          if (xfer) rd_ptr_q <= rd_ptr_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Outputs: stream signals from DELIVER, error pulses in the offending cycle.
  always_comb begin
    valid_o     = 1'b0;
    data_o      = '0;
    last_o      = 1'b0;
    frame_ok_o  = 1'b0;
    frame_err_o = 1'b0;
    err_code_o  = ERR_LEN;
    busy_o      = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (ovr_pend_q) begin
          frame_err_o = 1'b1;
          err_code_o  = ERR_OVERRUN;
        end
      end
      LEN: begin
        if (byte_stb_i && len_bad) begin
          frame_err_o = 1'b1;
          err_code_o  = ERR_LEN;
        end
      end
      CSUM: begin
        if (byte_stb_i && csum_bad) begin
          frame_err_o = 1'b1;
          err_code_o  = ERR_CSUM;
        end
      end
      DELIVER: begin
        valid_o    = 1'b1;
        data_o     = rd_data;
        last_o     = rd_last;
        frame_ok_o = last_xfer;
        if (byte_stb_i && !last_xfer) begin
          frame_err_o = 1'b1;
          err_code_o  = ERR_OVERRUN;
        end
      end
      default: ;
    endcase
    if (timeout_hit) begin
      frame_err_o = 1'b1;
      err_code_o  = ERR_TIMEOUT;
    end
  end

endmodule
